// File: rtl/mem_master.sv
// Single-request bus initiator for the 128x8 RAM: drives en/read/write strobes,
// waits for ready with a bounded timeout, and reports done/err to the control unit.
module mem_master #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last ACCESS cycle index before giving up; the counter never exceeds it.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            mem_en       <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        mem_address  <= req_addr;
                        mem_wdata    <= req_wdata;
                        mem_en       <= 1'b1;
                        mem_read     <= ~req_we;
                        mem_write    <= req_we;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= ACCESS;
                    end
                end

                ACCESS: begin
                    // Ready wins over the timeout when both land on the same edge.
                    if (mem_ready) begin
                        if (mem_read) begin
                            rdata <= mem_rdata;
                        end
                        done      <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_reg <= DONE;
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        err       <= 1'b1;
                        done      <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
